// File: rtl/snes_multi_poller.sv
// Polls up to four SNES pads sharing one latch/pulse pair and reports debounced-free
// button state plus per-bit press/release edges once per completed read.
module snes_multi_poller #(
  parameter int NUM_PADS     = 2,
  parameter int NUM_BITS     = 12,
  parameter int HALF_PERIOD  = 2,
  parameter int LATCH_CYCLES = 4,
  parameter int POLL_CYCLES  = 266667
) (
  input  logic                         sys_clk,
  input  logic                         sys_reset,
  input  logic                         auto_mode,
  input  logic                         read_enable,
  input  logic [NUM_PADS-1:0]          snes_data,
  output logic                         snes_latch,
  output logic                         snes_pulse,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic [NUM_PADS*NUM_BITS-1:0] released,
  output logic                         busy,
  output logic                         read_complete
);

  localparam int W    = NUM_PADS * NUM_BITS;
  localparam int TMAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = 4;
  localparam int PW   = 20;

  typedef enum logic [2:0] {IDLE, LATCH, WAIT, SHIFT_HI, SHIFT_LO, DONE} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [W-1:0]    buttons_q, buttons_d;
  logic [W-1:0]    pressed_q, pressed_d;
  logic [W-1:0]    released_q, released_d;
  logic            latch_q, pulse_q, busy_q, rc_q;
  logic            poll_expired, trigger, sample;

  assign poll_expired = (pcnt_q == PW'(POLL_CYCLES - 1));
  assign trigger      = (state_q == IDLE) &&
                        ((!auto_mode && read_enable) || (auto_mode && poll_expired));

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    sample     = 1'b0;
    case (state_q)
      IDLE: if (trigger) begin
        state_d = LATCH;
        tcnt_d  = '0;
      end
      LATCH: if (tcnt_q == TW'(LATCH_CYCLES - 1)) begin
        sample  = 1'b1;
        state_d = WAIT;
        tcnt_d  = '0;
      end else tcnt_d = tcnt_q + 1'b1;
      WAIT: if (tcnt_q == TW'(HALF_PERIOD - 1)) begin
        state_d = SHIFT_HI;
        tcnt_d  = '0;
        bcnt_d  = '0;
      end else tcnt_d = tcnt_q + 1'b1;
      SHIFT_HI: if (tcnt_q == TW'(HALF_PERIOD - 1)) begin
        sample  = 1'b1;
        state_d = SHIFT_LO;
        tcnt_d  = '0;
        bcnt_d  = bcnt_q + 1'b1;
      end else tcnt_d = tcnt_q + 1'b1;
      SHIFT_LO: if (tcnt_q == TW'(HALF_PERIOD - 1)) begin
        tcnt_d  = '0;
        state_d = (bcnt_q == BW'(NUM_BITS - 1)) ? DONE : SHIFT_HI;
      end else tcnt_d = tcnt_q + 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pads shift in lock-step; the first bit read ends up at the MSB of each field.
    shreg_d = shreg_q;
    if (sample) begin
      for (int i = 0; i < NUM_PADS; i++)
        shreg_d[i*NUM_BITS +: NUM_BITS] = {shreg_q[i*NUM_BITS +: NUM_BITS-1], ~snes_data[i]};
    end

    buttons_d  = buttons_q;
    pressed_d  = '0;
    released_d = '0;
    if (state_d == DONE) begin
      buttons_d  = shreg_q;
      pressed_d  = shreg_q & ~buttons_q;
      released_d = buttons_q & ~shreg_q;
    end

    pcnt_d = pcnt_q;
    if (!auto_mode || trigger) pcnt_d = '0;
    else if (!poll_expired)    pcnt_d = pcnt_q + 1'b1;
  end

  // NOTE: state uses non-blocking assignments and an asynchronous reset that clears every
  // register, including the shift registers, so reset never waits for a clock edge.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q    <= IDLE;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      pcnt_q     <= '0;
      shreg_q    <= '0;
      buttons_q  <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      latch_q    <= 1'b0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      rc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      pcnt_q     <= pcnt_d;
      shreg_q    <= shreg_d;
      buttons_q  <= buttons_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      latch_q    <= (state_d == LATCH);
      pulse_q    <= (state_d == SHIFT_HI);
      busy_q     <= (state_d != IDLE);
      rc_q       <= (state_d == DONE);
    end
  end

  assign snes_latch    = latch_q;
  assign snes_pulse    = pulse_q;
  assign busy          = busy_q;
  assign read_complete = rc_q;
  assign buttons       = buttons_q;
  assign pressed       = pressed_q;
  assign released      = released_q;

endmodule

// File: tb/tb_snes_multi_poller.sv
// Directed bench for snes_multi_poller: two modelled pads, table-driven reads plus
// hand-written multi-trigger, auto-poll and mid-transaction reset sequences.
module tb_snes_multi_poller;

  localparam int NB = 12;
  localparam int W  = 2 * NB;

  logic         clk = 1'b0;
  logic         sys_reset = 1'b1;
  logic         auto_mode = 1'b0;
  logic         read_enable = 1'b0;
  logic [1:0]   snes_data;
  logic         snes_latch, snes_pulse, busy, read_complete;
  logic [W-1:0] buttons, pressed, released;

  int checks = 0;
  int errors = 0;

  snes_multi_poller #(
    .NUM_PADS(2), .NUM_BITS(NB), .HALF_PERIOD(2), .LATCH_CYCLES(4), .POLL_CYCLES(100)
  ) dut (
    .sys_clk(clk), .sys_reset(sys_reset), .auto_mode(auto_mode), .read_enable(read_enable),
    .snes_data(snes_data), .snes_latch(snes_latch), .snes_pulse(snes_pulse),
    .buttons(buttons), .pressed(pressed), .released(released),
    .busy(busy), .read_complete(read_complete)
  );

  always #5 clk = ~clk;

  // Pad model: latch reloads bit 0 (MSB of pad_btn), each pulse rise advances one bit.
  logic [NB-1:0] pad_btn [2];
  int idx = 0;

  always @(posedge snes_pulse or posedge snes_latch) begin
    if (snes_latch) idx <= 0;
    else            idx <= idx + 1;
  end

  always_comb begin
    snes_data = 2'b00;
    for (int p = 0; p < 2; p++) begin
      if (idx < NB) snes_data[p] = ~pad_btn[p][NB-1-idx];
      else          snes_data[p] = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Manual read: trigger in cycle 0, observe cycles 1..60 against the expected waveform.
  task automatic do_read(input bit multi, output int lat, output int rc_cnt, output int stray,
                         output int wave_err, output logic [W-1:0] b, output logic [W-1:0] p,
                         output logic [W-1:0] r);
    bit el, ep, eb;
    lat = -1; rc_cnt = 0; stray = 0; wave_err = 0; b = '0; p = '0; r = '0;
    read_enable = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick;
      read_enable = multi && (c == 10 || c == 30);
      if (read_complete) begin
        rc_cnt++;
        if (lat < 0) begin
          lat = c; b = buttons; p = pressed; r = released;
        end
      end else if (pressed != '0 || released != '0) stray++;
      el = (c >= 1 && c <= 4);
      ep = (c >= 7 && c <= 50 && ((c - 7) % 4) < 2);
      eb = (c <= 51);
      if (snes_latch !== el || snes_pulse !== ep || busy !== eb) wave_err++;
    end
    read_enable = 1'b0;
  endtask

  typedef struct {
    logic [NB-1:0] pad0;
    logic [NB-1:0] pad1;
    logic [W-1:0]  eb;
    logic [W-1:0]  ep;
    logic [W-1:0]  er;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat, rc_cnt, stray, wave_err, n, quiet;
    logic [W-1:0] b, p, r;
    int t [3];

    vecs[0] = '{12'h800, 12'h001, 24'h001800, 24'h001800, 24'h000000};
    vecs[1] = '{12'h400, 12'h001, 24'h001400, 24'h000400, 24'h000800};
    vecs[2] = '{12'hFFF, 12'h000, 24'h000FFF, 24'h000BFF, 24'h001000};
    vecs[3] = '{12'h000, 12'hA5A, 24'hA5A000, 24'hA5A000, 24'h000FFF};
    vecs[4] = '{12'h000, 12'hA5A, 24'hA5A000, 24'h000000, 24'h000000};

    pad_btn[0] = '0;
    pad_btn[1] = '0;
    #1;
    check("reset_latch", snes_latch, 0);
    check("reset_pulse", snes_pulse, 0);
    check("reset_busy", busy, 0);
    check("reset_rc", read_complete, 0);
    check("reset_buttons", buttons, 0);
    repeat (3) tick;
    sys_reset = 1'b0;
    repeat (3) tick;

    for (int v = 0; v < 5; v++) begin
      pad_btn[0] = vecs[v].pad0;
      pad_btn[1] = vecs[v].pad1;
      do_read(1'b0, lat, rc_cnt, stray, wave_err, b, p, r);
      check($sformatf("v%0d_latency", v), lat, 51);
      check($sformatf("v%0d_rc_count", v), rc_cnt, 1);
      check($sformatf("v%0d_buttons", v), b, vecs[v].eb);
      check($sformatf("v%0d_pressed", v), p, vecs[v].ep);
      check($sformatf("v%0d_released", v), r, vecs[v].er);
      check($sformatf("v%0d_stray_edges", v), stray, 0);
      check($sformatf("v%0d_waveform", v), wave_err, 0);
    end

    // Extra read_enable pulses while busy must neither queue nor restart a read.
    do_read(1'b1, lat, rc_cnt, stray, wave_err, b, p, r);
    check("multi_latency", lat, 51);
    check("multi_rc_count", rc_cnt, 1);
    check("multi_buttons", b, 24'hA5A000);

    // Auto polling every 100 cycles, then stop cleanly.
    auto_mode = 1'b1;
    n = 0;
    for (int c = 0; c < 500 && n < 3; c++) begin
      tick;
      if (read_complete) begin
        t[n] = c;
        n++;
      end
    end
    auto_mode = 1'b0;
    check("auto_count", n, 3);
    if (n == 3) begin
      check("auto_period_1", t[1] - t[0], 100);
      check("auto_period_2", t[2] - t[1], 100);
    end
    check("auto_buttons", buttons, 24'hA5A000);
    quiet = 0;
    repeat (300) begin
      tick;
      if (read_complete) quiet++;
    end
    check("auto_off_no_reads", quiet, 0);
    check("auto_off_idle", busy, 0);

    // Reset at cycle 20 of a transaction (while snes_pulse is high).
    pad_btn[0] = 12'h123;
    pad_btn[1] = 12'h456;
    read_enable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick;
      read_enable = 1'b0;
    end
    check("pre_reset_pulse", snes_pulse, 1);
    sys_reset = 1'b1;
    #1;
    check("midrst_latch", snes_latch, 0);
    check("midrst_pulse", snes_pulse, 0);
    check("midrst_busy", busy, 0);
    check("midrst_buttons", buttons, 0);
    check("midrst_rc", read_complete, 0);
    tick;
    tick;
    sys_reset = 1'b0;
    quiet = 0;
    repeat (60) begin
      tick;
      if (read_complete || busy) quiet++;
    end
    check("post_reset_quiet", quiet, 0);
    do_read(1'b0, lat, rc_cnt, stray, wave_err, b, p, r);
    check("post_reset_latency", lat, 51);
    check("post_reset_buttons", b, 24'h456123);
    check("post_reset_pressed", p, 24'h456123);
    check("post_reset_released", r, 24'h000000);
    check("post_reset_waveform", wave_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
